// File: rtl/word_packer_if.sv
// rtl/word_packer_if.sv - beat input, flush and FIFO write-port bundle for word_packer
interface word_packer_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 256
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic             fifo_full;
    logic             fifo_wr_en;
    logic [OUT_W-1:0] fifo_data;

    // master: the environment feeding beats and owning the FIFO
    modport master (
        output in_data, in_valid, flush, fifo_full,
        input  in_ready, fifo_wr_en, fifo_data
    );

    // slave: the packer itself
    modport slave (
        input  in_data, in_valid, flush, fifo_full,
        output in_ready, fifo_wr_en, fifo_data
    );
endinterface

// File: rtl/word_packer.sv
// rtl/word_packer.sv - packs IN_W-bit beats into OUT_W-bit FIFO words; optional WORD_PACKER_STATS_EN word counter
module word_packer #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 256
) (
    input  logic          clk,
    input  logic          reset_n,
    word_packer_if.slave  bus,
    output logic [15:0]   word_count
);
    localparam int BEATS = OUT_W / IN_W;
    localparam int CNT_W = $clog2(BEATS) + 1;

    typedef enum logic {FILL, HOLD} state_t;

    state_t             state;
    logic [CNT_W-1:0]   beat_cnt;
    logic [OUT_W-1:0]   word;
    logic               accept;
    logic               last_beat;

    // in_ready is gated by reset_n so no beat is taken while reset is held
    assign bus.in_ready   = (state == FILL) && reset_n;
    assign accept         = bus.in_valid && bus.in_ready;
    assign bus.fifo_wr_en = (state == HOLD) && !bus.fifo_full;
    assign bus.fifo_data  = word;
    assign last_beat      = (beat_cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FILL;
            beat_cnt <= '0;
            word     <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (beat_cnt == CNT_W'(k))
                                word[k*IN_W +: IN_W] <= bus.in_data;
                        end
                        if (last_beat || bus.flush) begin
                            state    <= HOLD;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else if (bus.flush && (beat_cnt != '0)) begin
                        state    <= HOLD;
                        beat_cnt <= '0;
                    end
                end
                HOLD: begin
                    // clearing here guarantees unfilled lanes of the next word read zero
                    if (!bus.fifo_full) begin
                        state <= FILL;
                        word  <= '0;
                    end
                end
                default: begin
                    state    <= FILL;
                    beat_cnt <= '0;
                    word     <= '0;
                end
            endcase
        end
    end

`ifdef WORD_PACKER_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            word_count <= 16'h0000;
        else if (bus.fifo_wr_en)
            word_count <= word_count + 16'h0001;
    end
`else
    assign word_count = 16'h0000;
`endif
endmodule

// File: tb/tb_word_packer.sv
// tb/tb_word_packer.sv - directed self-checking bench for word_packer
module tb_word_packer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] word_count;
    int          tests = 0;
    int          fails = 0;
    int          wr_count = 0;
    int          consec = 0;
    logic        prev_wr = 1'b0;
    int          base;
    logic [255:0] held;

    word_packer_if #(.IN_W(32), .OUT_W(256)) bus();

    word_packer #(.IN_W(32), .OUT_W(256)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.fifo_wr_en) wr_count++;
        if (bus.fifo_wr_en && prev_wr) consec++;
        prev_wr = bus.fifo_wr_en;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic fl);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.flush    = fl;
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.in_data  = '0;
    endtask

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.fifo_full = 1'b0;
        #1;
        chk("rst_in_ready", 256'(bus.in_ready), 256'd0);
        chk("rst_wr_en", 256'(bus.fifo_wr_en), 256'd0);
        chk("rst_data", bus.fifo_data, 256'd0);
        chk("rst_word_count", 256'(word_count), 256'd0);
        tick(); tick();
        reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 256'(bus.in_ready), 256'd1);

        // full word of beats 0..7
        base = wr_count;
        for (int i = 0; i < 8; i++) send_beat(32'(i), 1'b0);
        chk("full_wr_en", 256'(bus.fifo_wr_en), 256'd1);
        chk("full_in_ready", 256'(bus.in_ready), 256'd0);
        chk("full_data", bus.fifo_data,
            256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
        tick();
        chk("full_after_in_ready", 256'(bus.in_ready), 256'd1);
        chk("full_after_wr_en", 256'(bus.fifo_wr_en), 256'd0);
        chk("full_writes", 256'(wr_count - base), 256'd1);

        // three beats then a bare flush
        base = wr_count;
        send_beat(32'hAAAA0001, 1'b0);
        send_beat(32'hBBBB0002, 1'b0);
        send_beat(32'hCCCC0003, 1'b0);
        chk("partial_no_wr", 256'(bus.fifo_wr_en), 256'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush3_wr_en", 256'(bus.fifo_wr_en), 256'd1);
        chk("flush3_data", bus.fifo_data, {160'h0, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001});
        tick();
        chk("flush3_writes", 256'(wr_count - base), 256'd1);

        // flush together with the second beat
        base = wr_count;
        send_beat(32'h1111000A, 1'b0);
        send_beat(32'h2222000D, 1'b1);
        chk("flush_same_wr_en", 256'(bus.fifo_wr_en), 256'd1);
        chk("flush_same_data", bus.fifo_data, {192'h0, 32'h2222000D, 32'h1111000A});
        tick();
        chk("flush_same_writes", 256'(wr_count - base), 256'd1);

        // flush with an empty word is ignored
        base = wr_count;
        bus.flush = 1'b1;
        #1;
        chk("empty_flush_wr_en", 256'(bus.fifo_wr_en), 256'd0);
        tick();
        bus.flush = 1'b0;
        tick();
        chk("empty_flush_in_ready", 256'(bus.in_ready), 256'd1);
        chk("empty_flush_writes", 256'(wr_count - base), 256'd0);

        // FIFO full when the word completes
        base = wr_count;
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 8; i++) send_beat(32'h50 + 32'(i), 1'b0);
        held = 256'h00000057_00000056_00000055_00000054_00000053_00000052_00000051_00000050;
        for (int c = 0; c < 5; c++) begin
            chk("full_hold_wr_en", 256'(bus.fifo_wr_en), 256'd0);
            chk("full_hold_in_ready", 256'(bus.in_ready), 256'd0);
            chk("full_hold_data", bus.fifo_data, held);
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hDEADBEEF;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("full_hold_writes", 256'(wr_count - base), 256'd0);
        bus.fifo_full = 1'b0;
        #1;
        chk("full_release_wr_en", 256'(bus.fifo_wr_en), 256'd1);
        chk("full_release_data", bus.fifo_data, held);
        tick();
        chk("full_release_writes", 256'(wr_count - base), 256'd1);
        chk("full_release_in_ready", 256'(bus.in_ready), 256'd1);

        // reset in the middle of a word
        for (int i = 0; i < 5; i++) send_beat(32'hEE00 + 32'(i), 1'b0);
        base = wr_count;
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_in_ready", 256'(bus.in_ready), 256'd0);
        chk("midrst_wr_en", 256'(bus.fifo_wr_en), 256'd0);
        chk("midrst_data", bus.fifo_data, 256'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("midrst_writes", 256'(wr_count - base), 256'd0);
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 8; i++) send_beat(32'h10 + 32'(i), 1'b0);
            if (w == 0)
                chk("midrst_new_data", bus.fifo_data,
                    256'h00000017_00000016_00000015_00000014_00000013_00000012_00000011_00000010);
            tick();
        end
        chk("midrst_new_writes", 256'(wr_count - base), 256'd3);
`ifdef WORD_PACKER_STATS_EN
        chk("word_count", 256'(word_count), 256'd3);
`else
        chk("word_count_tied", 256'(word_count), 256'd0);
`endif
        chk("no_consecutive_wr", 256'(consec), 256'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
